// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter owning the select of a shared 8:1 mux, with a per-grant hold limit.
// Grant/sel/busy are registered: one cycle from request to grant, zero dead cycles on hand-over.
module mux8_rr_arbiter #(
    parameter int N_REQ    = 8,
    parameter int SEL_W    = 3,
    parameter int MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] grant,
    output logic [SEL_W-1:0] sel,
    output logic             busy,
    output logic [2:0]       hold_cnt
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    localparam logic [2:0] HOLD_LAST = 3'(MAX_HOLD - 1);

    state_t           state;
    logic [SEL_W-1:0] last;

    logic [N_REQ-1:0] others;
    logic             owner_req;
    logic             others_any;
    logic             at_limit;
    logic [SEL_W-1:0] win_idle;
    logic [SEL_W-1:0] win_rot;

    // First set bit of mask strictly after base, wrapping; base itself is checked last.
    function automatic logic [SEL_W-1:0] rr_pick(input logic [SEL_W-1:0] base,
                                                 input logic [N_REQ-1:0] mask);
        logic [SEL_W-1:0] idx;
        logic             found;
        rr_pick = base;
        found   = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = SEL_W'((int'(base) + k) % N_REQ);
            if (!found && mask[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

    function automatic logic [N_REQ-1:0] decode(input logic [SEL_W-1:0] idx);
        decode      = '0;
        decode[idx] = 1'b1;
    endfunction

    always_comb begin
        others     = req & ~grant;
        owner_req  = req[sel];
        others_any = |others;
        at_limit   = (hold_cnt == HOLD_LAST);
        win_idle   = rr_pick(last, req);
        win_rot    = rr_pick(sel, others);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            last     <= SEL_W'(N_REQ - 1);
            grant    <= '0;
            sel      <= '0;
            busy     <= 1'b0;
            hold_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        state    <= GRANT;
                        sel      <= win_idle;
                        grant    <= decode(win_idle);
                        busy     <= 1'b1;
                        hold_cnt <= '0;
                    end
                end
                GRANT: begin
                    if (!owner_req) begin
                        last     <= sel;
                        hold_cnt <= '0;
                        if (others_any) begin
                            sel   <= win_rot;
                            grant <= decode(win_rot);
                        end else begin
                            state <= IDLE;
                            grant <= '0;
                            busy  <= 1'b0;
                        end
                    end else if (at_limit) begin
                        // Hold budget spent: rotate only if someone else is waiting.
                        hold_cnt <= '0;
                        if (others_any) begin
                            last  <= sel;
                            sel   <= win_rot;
                            grant <= decode(win_rot);
                        end
                    end else begin
                        hold_cnt <= hold_cnt + 3'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Scoreboard bench: stimulus pushes reference-model expectations, a monitor pops and compares.
module tb_mux8_rr_arbiter;

    localparam int MH = 4;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic [7:0] grant;
    logic [2:0] sel;
    logic       busy;
    logic [2:0] hold_cnt;

    mux8_rr_arbiter #(.N_REQ(8), .SEL_W(3), .MAX_HOLD(MH)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .grant    (grant),
        .sel      (sel),
        .busy     (busy),
        .hold_cnt (hold_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] g;
        logic [2:0] s;
        logic       b;
        logic [2:0] h;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   wait_cnt[8];

    // Reference model: owner index (-1 = nobody), last owner, cycles held.
    int m_owner = -1;
    int m_last  = 7;
    int m_sel   = 0;
    int m_hold  = 0;

    function automatic int next_after(input int start, input logic [7:0] mask);
        for (int k = 1; k <= 8; k++) begin
            if (mask[(start + k) % 8]) return (start + k) % 8;
        end
        return -1;
    endfunction

    task automatic model_step(input bit r, input logic [7:0] q);
        logic [7:0] rest;
        if (r) begin
            m_owner = -1; m_last = 7; m_sel = 0; m_hold = 0;
        end else if (m_owner < 0) begin
            if (q != 8'h00) begin
                m_owner = next_after(m_last, q);
                m_sel   = m_owner;
                m_hold  = 0;
            end
        end else begin
            rest = q;
            rest[m_owner] = 1'b0;
            if (!q[m_owner]) begin
                m_last = m_owner;
                m_hold = 0;
                if (rest != 8'h00) begin
                    m_owner = next_after(m_owner, rest);
                    m_sel   = m_owner;
                end else begin
                    m_owner = -1;
                end
            end else if (m_hold == MH - 1) begin
                m_hold = 0;
                if (rest != 8'h00) begin
                    m_last  = m_owner;
                    m_owner = next_after(m_owner, rest);
                    m_sel   = m_owner;
                end
            end else begin
                m_hold = m_hold + 1;
            end
        end
    endtask

    task automatic check(input string name, input int act, input int req_v);
        checks++;
        if (act != req_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req_v, $time);
        end
    endtask

    // One cycle: inputs change on the falling edge, the expectation covers the next rising edge.
    task automatic cyc(input bit r, input logic [7:0] q, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (r && !rst) begin
                rst = 1'b1;
                #1;
                check("async_rst_grant", int'(grant), 0);
                check("async_rst_sel", int'(sel), 0);
                check("async_rst_busy", int'(busy), 0);
                check("async_rst_hold", int'(hold_cnt), 0);
            end
            rst = r;
            req = q;
            model_step(r, q);
            e.g = (m_owner < 0) ? 8'h00 : (8'h01 << m_owner);
            e.s = 3'(m_sel);
            e.b = (m_owner >= 0);
            e.h = 3'(m_hold);
            exp_q.push_back(e);
        end
    endtask

    initial begin : monitor
        exp_t e;
        int   idx;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("grant", int'(grant), int'(e.g));
                check("sel", int'(sel), int'(e.s));
                check("busy", int'(busy), int'(e.b));
                check("hold_cnt", int'(hold_cnt), int'(e.h));
                checks++;
                if (!$onehot0(grant)) begin
                    errors++;
                    $display("FAIL onehot: grant=%02h", grant);
                end
                if (grant != 8'h00) begin
                    idx = 0;
                    for (int i = 0; i < 8; i++) if (grant[i]) idx = i;
                    check("sel_index", int'(sel), idx);
                end
                checks++;
                for (int i = 0; i < 8; i++) begin
                    if (rst || !req[i] || grant[i]) wait_cnt[i] = 0;
                    else wait_cnt[i] = wait_cnt[i] + 1;
                    if (wait_cnt[i] > 7 * MH) begin
                        errors++;
                        $display("FAIL starvation: slot %0d waited %0d required <= %0d",
                                 i, wait_cnt[i], 7 * MH);
                        wait_cnt[i] = 0;
                    end
                end
            end
        end
    end

    initial begin : stimulus
        logic [7:0] rq;
        int         guard;
        rst = 1'b1;
        req = 8'hFF;
        // Reset held with all requests, then slot 0 wins first.
        cyc(1'b1, 8'hFF, 3);
        cyc(1'b0, 8'hFF, 2);
        cyc(1'b0, 8'h00, 2);
        // Single requester held past the hold limit, then dropped.
        cyc(1'b1, 8'h00, 1);
        cyc(1'b0, 8'h10, 10);
        cyc(1'b0, 8'h00, 2);
        // Full contention: 4-cycle rotation through all slots and wrap.
        cyc(1'b1, 8'h00, 1);
        cyc(1'b0, 8'hFF, 40);
        cyc(1'b0, 8'h00, 2);
        // Slot 7 owner releases, slot 0 takes over on the same edge.
        cyc(1'b0, 8'h80, 1);
        cyc(1'b0, 8'h81, 2);
        cyc(1'b0, 8'h01, 3);
        cyc(1'b0, 8'h00, 2);
        // Reset mid-grant: priority restarts at slot 0, so slot 2 wins again.
        cyc(1'b1, 8'h00, 1);
        cyc(1'b0, 8'h0C, 2);
        cyc(1'b1, 8'h0C, 2);
        cyc(1'b0, 8'h0C, 6);
        cyc(1'b0, 8'h00, 2);
        // Randomized traffic with sticky requests and occasional resets.
        rq = 8'h00;
        for (int n = 0; n < 10000; n++) begin
            for (int b = 0; b < 8; b++) begin
                if ($urandom_range(7) == 0) rq[b] = ~rq[b];
            end
            cyc(($urandom_range(2999) == 0), rq, 1);
        end
        cyc(1'b0, 8'h00, 2);
        guard = 0;
        while (exp_q.size() > 0 && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        #2;
        checks++;
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
